// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: default datapath width, FSM states and ALUop codes.
package alu_arb_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_SLT = 4'd5;
  localparam logic [3:0] ALUOP_SLL = 4'd6;
  localparam logic [3:0] ALUOP_SRL = 4'd7;
  localparam logic [3:0] ALUOP_SRA = 4'd8;
  localparam logic [3:0] ALUOP_NOR = 4'd9;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters; codes outside the defined set produce zero.
module alu_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out,
  output logic             isZero
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic           a_lt_b;

  assign shamt  = B[SHW-1:0];
  assign a_lt_b = $signed(A) < $signed(B);

  always_comb begin
    Out = '0;
    case (ALUop)
      ALUOP_ADD: Out = A + B;
      ALUOP_SUB: Out = A - B;
      ALUOP_AND: Out = A & B;
      ALUOP_OR:  Out = A | B;
      ALUOP_XOR: Out = A ^ B;
      ALUOP_SLT: Out = {{(WIDTH-1){1'b0}}, a_lt_b};
      ALUOP_SLL: Out = A << shamt;
      ALUOP_SRL: Out = A >> shamt;
      ALUOP_SRA: Out = WIDTH'($signed(A) >>> shamt);
      ALUOP_NOR: Out = ~(A | B);
      default:   Out = '0;
    endcase
  end

  assign isZero = (Out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no round-robin state).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [3:0]       req0_ALUop,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [3:0]       req1_ALUop,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_Out,
  output logic             resp_isZero,
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [3:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             grant;
  logic             tie_pick;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  logic last_grant_q, last_grant_d;
  assign tie_pick = ~last_grant_q;
`endif

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = tie_pick;
    else if (req1_valid)          grant = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_d       = out_q;
    zero_d      = zero_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        if (req0_valid || req1_valid) begin
          id_d    = grant;
          a_d     = grant ? req1_A : req0_A;
          b_d     = grant ? req1_B : req0_B;
          op_d    = grant ? req1_ALUop : req0_ALUop;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_d   = alu_out;
        zero_d  = alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = ~id_q;
        resp1_valid = id_q;
        if ((~id_q && resp0_ready) || (id_q && resp1_ready)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves only when a request is actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && (req0_valid || req1_valid)) last_grant_d = grant;
  end

  always_ff @(posedge Clock) begin
    if (Reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .A      (a_q),
    .B      (b_q),
    .ALUop  (op_q),
    .Out    (alu_out),
    .isZero (alu_zero)
  );

  assign resp_Out    = out_q;
  assign resp_isZero = zero_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_alu_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0]  req0_ALUop, req1_ALUop;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_Out;
  logic        resp_isZero, busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 Clock = ~Clock;

  alu_arbiter #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_ALUop(req0_ALUop),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_ALUop(req1_ALUop),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_Out(resp_Out), .resp_isZero(resp_isZero), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return $unsigned($signed(a) >>> b[4:0]);
      4'd9: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Model: who would be accepted given the valids and the previous winner (-1 = nobody).
  bit          m_init = 0, m_pending = 0, m_id = 0, m_last = 1;
  int          m_age = 0;
  logic [31:0] m_res = 0;

  function automatic int pick(input logic v0, input logic v1, input bit last);
    if (v0 === 1'b1 && v1 === 1'b1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return last ? 0 : 1;
`endif
    end
    if (v0 === 1'b1) return 0;
    if (v1 === 1'b1) return 1;
    return -1;
  endfunction

  always @(posedge Clock) begin
    int g;
    if (Reset === 1'b1) begin
      m_init <= 1; m_pending <= 0; m_last <= 1; m_age <= 0;
    end else if (m_init) begin
      if (!m_pending) begin
        g = pick(req0_valid, req1_valid, m_last);
        if (g >= 0) begin
          m_pending <= 1; m_age <= 0; m_id <= (g == 1); m_last <= (g == 1);
          m_res <= (g == 1) ? alu_ref(req1_A, req1_B, req1_ALUop) : alu_ref(req0_A, req0_B, req0_ALUop);
        end
      end else if (m_age == 0) begin
        m_age <= 1;
      end else if ((m_id ? resp1_ready : resp0_ready) === 1'b1) begin
        $display("txn: resp%0d out=%08h zero=%0d", m_id, m_res, (m_res == 0));
        m_pending <= 0;
      end
    end
  end

  always @(negedge Clock) begin
    int g;
    bit er0, er1, ev0, ev1;
    if (m_init) begin
      er0 = 0; er1 = 0;
      if (!m_pending) begin
        g = pick(req0_valid, req1_valid, m_last);
        er0 = (g == 0); er1 = (g == 1);
      end
      ev0 = m_pending && m_age > 0 && !m_id;
      ev1 = m_pending && m_age > 0 && m_id;
      chk("busy", busy, m_pending);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("resp0_valid", resp0_valid, ev0);
      chk("resp1_valid", resp1_valid, ev1);
      if (ev0 || ev1) begin
        chk("resp_Out", resp_Out, m_res);
        chk("resp_isZero", resp_isZero, m_res == 0);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit done;
    if (id) begin req1_valid = 1; req1_A = a; req1_B = b; req1_ALUop = op; end
    else    begin req0_valid = 1; req0_A = a; req0_B = b; req0_ALUop = op; end
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge Clock);
      if ((id ? req1_ready : req0_ready) === 1'b1) done = 1;
      step();
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    chk("accept_in_time", done, 1);
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge Clock);
      if ((id ? resp1_valid : resp0_valid) === 1'b1) done = 1;
      step();
    end
    chk("resp_in_time", done, 1);
  endtask

  typedef struct { bit id; logic [31:0] a; logic [31:0] b; logic [3:0] op; } vec_t;
  vec_t vt[10];
  int   grants[4];
  int   ng;

  initial begin
    vt[0] = '{0, 32'hFFFF_FFFF, 32'd1,        4'd0};
    vt[1] = '{1, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd2};
    vt[2] = '{0, 32'h0000_00A0, 32'h0000_0005, 4'd3};
    vt[3] = '{1, 32'hAAAA_5555, 32'hFFFF_0000, 4'd4};
    vt[4] = '{0, 32'hFFFF_FFFF, 32'd1,        4'd5};
    vt[5] = '{1, 32'd1,         32'd31,       4'd6};
    vt[6] = '{0, 32'h8000_0000, 32'd4,        4'd7};
    vt[7] = '{1, 32'h8000_0000, 32'd4,        4'd8};
    vt[8] = '{0, 32'h0000_000F, 32'h0000_00F0, 4'd9};
    vt[9] = '{1, 32'h1234_5678, 32'h1,        4'hF};

    Reset = 1; req0_valid = 0; req1_valid = 0;
    req0_A = 0; req0_B = 0; req0_ALUop = 0; req1_A = 0; req1_B = 0; req1_ALUop = 0;
    resp0_ready = 0; resp1_ready = 0;
    repeat (3) step();
    @(negedge Clock);
    chk("rst_busy", busy, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_resp_Out", resp_Out, 0);
    chk("rst_resp_isZero", resp_isZero, 0);
    Reset = 0;
    step();

    // 5 - 4 on requester 0: response visible two edges after acceptance
    resp0_ready = 1; resp1_ready = 1;
    req0_valid = 1; req0_A = 5; req0_B = 4; req0_ALUop = 4'd1;
    @(negedge Clock); chk("A_req0_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    @(negedge Clock); chk("A_exec_resp0_valid", resp0_valid, 0);
    step();
    @(negedge Clock);
    chk("A_resp0_valid", resp0_valid, 1);
    chk("A_resp_Out", resp_Out, 1);
    chk("A_resp_isZero", resp_isZero, 0);
    chk("A_resp1_valid", resp1_valid, 0);
    step();
    @(negedge Clock); chk("A_back_idle", busy, 0);

    // 5 - 5 on requester 1 gives zero
    req1_valid = 1; req1_A = 5; req1_B = 5; req1_ALUop = 4'd1;
    step();
    req1_valid = 0;
    step();
    @(negedge Clock);
    chk("B_resp1_valid", resp1_valid, 1);
    chk("B_resp_Out", resp_Out, 0);
    chk("B_resp_isZero", resp_isZero, 1);
    step();

    // Both requesters valid continuously: record grant order
    req0_valid = 1; req0_A = 3; req0_B = 1; req0_ALUop = 4'd0;
    req1_valid = 1; req1_A = 9; req1_B = 2; req1_ALUop = 4'd1;
    ng = 0;
    for (int n = 0; n < 40 && ng < 4; n++) begin
      @(negedge Clock);
      if (req0_ready === 1'b1) begin grants[ng] = 0; ng++; end
      else if (req1_ready === 1'b1) begin grants[ng] = 1; ng++; end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    chk("C_grant_count", ng, 4);
    for (int i = 0; i < ng && i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk($sformatf("C_grant%0d", i), grants[i], 0);
`else
      chk($sformatf("C_grant%0d", i), grants[i], i % 2);
`endif
    end
    repeat (4) step();

    // Response back-pressure: hold resp0_ready low five cycles
    resp0_ready = 0; resp1_ready = 1;
    req0_valid = 1; req0_A = 10; req0_B = 3; req0_ALUop = 4'd0;
    step();
    req0_valid = 0;
    req1_valid = 1; req1_A = 1; req1_B = 1; req1_ALUop = 4'd0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("D_hold_valid", resp0_valid, 1);
      chk("D_hold_out", resp_Out, 13);
      chk("D_hold_zero", resp_isZero, 0);
      chk("D_hold_r0", req0_ready, 0);
      chk("D_hold_r1", req1_ready, 0);
      chk("D_hold_busy", busy, 1);
      step();
    end
    resp0_ready = 1;
    step();
    @(negedge Clock); chk("D_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    repeat (4) step();

    // Reset during EXEC aborts the in-flight op
    req0_valid = 1; req0_A = 2; req0_B = 2; req0_ALUop = 4'd1;
    step();
    req0_valid = 0; Reset = 1;
    step();
    Reset = 0;
    @(negedge Clock);
    chk("E_busy", busy, 0);
    chk("E_resp0_valid", resp0_valid, 0);
    chk("E_resp1_valid", resp1_valid, 0);
    repeat (3) step();
    run_op(1, 32'd7, 32'd3, 4'd0);

    // Operands changed while waiting: values at handshake are the ones used
    req1_valid = 1; req1_A = 4; req1_B = 4; req1_ALUop = 4'd2;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_A = 9; req0_B = 2; req0_ALUop = 4'd1;
    step();
    req0_A = 20; req0_B = 6; req0_ALUop = 4'd0;
    ng = 0;
    for (int n = 0; n < 20 && ng == 0; n++) begin
      @(negedge Clock);
      if (req0_ready === 1'b1) ng = 1;
      step();
    end
    chk("F_accept", ng, 1);
    req0_valid = 0; req0_A = 32'hDEAD_BEEF; req0_B = 1; req0_ALUop = 4'd1;
    step();
    @(negedge Clock);
    chk("F_resp0_valid", resp0_valid, 1);
    chk("F_resp_Out", resp_Out, 26);
    step();

    foreach (vt[i]) run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
